// File: rtl/seven_segment_reader.sv
// Samples an externally driven two-digit seven-segment display and decodes each settled digit to hex.
// Optional macro SEVSEG_READER_ERRCNT_EN enables a saturating count of illegal captures on err_count.
module seven_segment_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] seg,
    input  logic [1:0] an,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] valid,
    output logic [1:0] bad,
    output logic       upd,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        ARMED  = 2'd1,
        HELD   = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    // Inverse of the hex display table; bit 4 flags a legal pattern.
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        logic [4:0] d;
        case (p)
            7'b1000000: d = {1'b1, 4'h0};
            7'b1111001: d = {1'b1, 4'h1};
            7'b0100100: d = {1'b1, 4'h2};
            7'b0110000: d = {1'b1, 4'h3};
            7'b0011001: d = {1'b1, 4'h4};
            7'b0010010: d = {1'b1, 4'h5};
            7'b0000010: d = {1'b1, 4'h6};
            7'b1111000: d = {1'b1, 4'h7};
            7'b0000000: d = {1'b1, 4'h8};
            7'b0010000: d = {1'b1, 4'h9};
            7'b0001000: d = {1'b1, 4'hA};
            7'b0000011: d = {1'b1, 4'hB};
            7'b1000110: d = {1'b1, 4'hC};
            7'b0100001: d = {1'b1, 4'hD};
            7'b0000110: d = {1'b1, 4'hE};
            7'b0001110: d = {1'b1, 4'hF};
            default:    d = 5'b0_0000;
        endcase
        return d;
    endfunction

    logic [8:0] r_sync1;
    logic [8:0] r_sync2;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_eval;
    logic [3:0] r_digit0;
    logic [3:0] r_digit1;
    logic [1:0] r_valid;
    logic [1:0] r_bad;
    logic       r_upd;

    // s changes on the edge where the second stage takes a differing first-stage value.
    logic       w_changed;
    logic [1:0] w_an;
    logic [6:0] w_seg;
    logic       w_sel0;
    logic       w_sel1;
    logic [4:0] w_dec;
    logic       w_cap;
    logic       w_legal;

    assign w_changed = (r_sync1 != r_sync2);
    assign w_an      = r_sync2[8:7];
    assign w_seg     = r_sync2[6:0];
    assign w_sel0    = (w_an == 2'b10);
    assign w_sel1    = (w_an == 2'b01);
    assign w_dec     = f_decode(w_seg);
    assign w_legal   = w_dec[4];
    assign w_cap     = w_eval && (w_sel0 || w_sel1) && (w_seg != 7'h7F);

    // Two-flop synchronizer for the asynchronous display pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 9'h000;
            r_sync2 <= 9'h000;
        end else begin
            r_sync1 <= {an, seg};
            r_sync2 <= r_sync1;
        end
    end

    // Settle FSM state and stability counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SETTLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: any change of s restarts the settle from zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_eval      = (r_state == ARMED);
        if (w_changed) begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (r_cnt == STABLE_LAST) begin
                        w_state_nxt = ARMED;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ARMED: begin
                    w_state_nxt = HELD;
                end
                HELD: begin
                    w_state_nxt = HELD;
                end
                default: begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Capture registers: a legal pattern loads the digit, an illegal one only flags it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit0 <= 4'h0;
            r_digit1 <= 4'h0;
            r_valid  <= 2'b00;
            r_bad    <= 2'b00;
            r_upd    <= 1'b0;
        end else begin
            r_upd <= w_cap;
            if (w_cap && w_sel0) begin
                if (w_legal) begin
                    r_digit0   <= w_dec[3:0];
                    r_valid[0] <= 1'b1;
                    r_bad[0]   <= 1'b0;
                end else begin
                    r_bad[0] <= 1'b1;
                end
            end else if (w_cap && w_sel1) begin
                if (w_legal) begin
                    r_digit1   <= w_dec[3:0];
                    r_valid[1] <= 1'b1;
                    r_bad[1]   <= 1'b0;
                end else begin
                    r_bad[1] <= 1'b1;
                end
            end
        end
    end

`ifdef SEVSEG_READER_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of illegal captures.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= 8'h00;
        end else if (w_cap && !w_legal && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'h00;
`endif

    assign digit0 = r_digit0;
    assign digit1 = r_digit1;
    assign valid  = r_valid;
    assign bad    = r_bad;
    assign upd    = r_upd;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed self-checking bench for seven_segment_reader with STABLE_CYCLES = 4.
module tb_seven_segment_reader;

`ifdef SEVSEG_READER_ERRCNT_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [1:0] valid;
    logic [1:0] bad;
    logic       upd;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;

    seven_segment_reader #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg       (seg),
        .an        (an),
        .digit0    (digit0),
        .digit1    (digit1),
        .valid     (valid),
        .bad       (bad),
        .upd       (upd),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd === 1'b1) upd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a, input logic [6:0] s);
        an  = a;
        seg = s;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_digit0"}, 32'(digit0), 32'h0);
        check_eq({tag, "_digit1"}, 32'(digit1), 32'h0);
        check_eq({tag, "_valid"},  32'(valid),  32'h0);
        check_eq({tag, "_bad"},    32'(bad),    32'h0);
        check_eq({tag, "_upd"},    32'(upd),    32'h0);
        check_eq({tag, "_err"},    32'(err_count), 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(2'b11, 7'b1111111);
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(10);
        check_eq("idle_no_upd", 32'(upd_cnt), 32'd0);

        // Legal "2" on digit 0: outputs must change exactly at edge 7.
        drive(2'b10, 7'b0100100);
        upd_cnt = 0;
        tick(6);
        check_eq("lat_before_digit0", 32'(digit0), 32'h0);
        check_eq("lat_before_upd",    32'(upd),    32'h0);
        tick(1);
        check_eq("lat_digit0", 32'(digit0), 32'h2);
        check_eq("lat_valid",  32'(valid),  32'h1);
        check_eq("lat_upd",    32'(upd),    32'h1);
        tick(1);
        check_eq("upd_one_cycle", 32'(upd), 32'h0);
        tick(2);
        check_eq("single_upd", 32'(upd_cnt), 32'd1);

        // Short-lived "3" on digit 1 is discarded, then "1" settles.
        upd_cnt = 0;
        drive(2'b01, 7'b0110000);
        tick(2);
        drive(2'b01, 7'b1111001);
        tick(12);
        check_eq("restart_digit1", 32'(digit1), 32'h1);
        check_eq("restart_valid",  32'(valid),  32'h3);
        check_eq("restart_upd",    32'(upd_cnt), 32'd1);

        // Illegal pattern on digit 0.
        upd_cnt = 0;
        drive(2'b10, 7'b1010101);
        tick(8);
        check_eq("illegal_bad",    32'(bad),    32'h1);
        check_eq("illegal_digit0", 32'(digit0), 32'h2);
        check_eq("illegal_valid",  32'(valid),  32'h3);
        check_eq("illegal_upd",    32'(upd_cnt), 32'd1);
        check_eq("illegal_err",    32'(err_count), ERR_EN ? 32'd1 : 32'd0);

        // No-capture cases: both/no enables, and blank segments.
        upd_cnt = 0;
        drive(2'b00, 7'b0000000);
        tick(10);
        drive(2'b11, 7'b0000000);
        tick(10);
        drive(2'b10, 7'b1111111);
        tick(10);
        check_eq("nocap_upd",    32'(upd_cnt), 32'd0);
        check_eq("nocap_digit0", 32'(digit0), 32'h2);
        check_eq("nocap_digit1", 32'(digit1), 32'h1);
        check_eq("nocap_bad",    32'(bad),    32'h1);

        // Alternating multiplexed digits.
        upd_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            drive(2'b10, 7'b0001000);
            tick(20);
            drive(2'b01, 7'b0110000);
            tick(20);
        end
        check_eq("mux_digit0", 32'(digit0), 32'hA);
        check_eq("mux_digit1", 32'(digit1), 32'h3);
        check_eq("mux_valid",  32'(valid),  32'h3);
        check_eq("mux_bad",    32'(bad),    32'h0);
        check_eq("mux_upd",    32'(upd_cnt), 32'd8);

        // Illegal on digit 1, then "E" on digit 0.
        drive(2'b01, 7'b0000001);
        tick(8);
        check_eq("ill1_bad",    32'(bad),    32'h2);
        check_eq("ill1_digit1", 32'(digit1), 32'h3);
        check_eq("ill1_err",    32'(err_count), ERR_EN ? 32'd2 : 32'd0);
        drive(2'b10, 7'b0000110);
        tick(8);
        check_eq("hexE_digit0", 32'(digit0), 32'hE);
        check_eq("hexE_bad",    32'(bad),    32'h2);

        // Reset in the middle of a settle.
        drive(2'b10, 7'b0000000);
        tick(5);
        reset_n = 1'b0;
        #2;
        check_all_zero("rst_settle");
        reset_n = 1'b1;
        tick(6);
        check_eq("rst_settle_early", 32'(digit0), 32'h0);
        tick(1);
        check_eq("rst_settle_digit0", 32'(digit0), 32'h8);
        check_eq("rst_settle_valid",  32'(valid),  32'h1);

        // Reset while HELD: the same value must fully settle again.
        tick(3);
        reset_n = 1'b0;
        #2;
        check_all_zero("rst_held");
        reset_n = 1'b1;
        upd_cnt = 0;
        tick(6);
        check_eq("rst_held_early", 32'(digit0), 32'h0);
        check_eq("rst_held_noupd", 32'(upd_cnt), 32'd0);
        tick(1);
        check_eq("rst_held_digit0", 32'(digit0), 32'h8);
        check_eq("rst_held_upd",    32'(upd),    32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, default 4, consecutive cycles a synchronized {an,seg} value must hold before capture (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: seg  input  7  observed segment lines, active-low, seg[0]=A .. seg[6]=G; asynchronous to clk.
REQ-005 SHALL have port: an  input  2  observed digit enables, active-low, an[0]=digit 0, an[1]=digit 1; asynchronous to clk.
REQ-006 SHALL have port: digit0  output  4  last legally decoded hex value for digit 0.
REQ-007 SHALL have port: digit1  output  4  last legally decoded hex value for digit 1.
REQ-008 SHALL have port: valid  output  2  valid[i]=1 once digit i has captured a legal pattern since reset.
REQ-009 SHALL have port: bad  output  2  bad[i]=1 when the most recent capture on digit i was an illegal pattern.
REQ-010 SHALL have port: upd  output  1  one-cycle pulse on every capture, legal or illegal.
REQ-011 SHALL have port: err_count  output  8  count of illegal captures (see Configuration).

Function
REQ-012 SHALL pass seg and an through a two-flop synchronizer; "s" denotes the 9-bit synchronized value {an,seg}.
REQ-013 SHALL implement states SETTLE, ARMED, HELD; SETTLE is entered whenever s differs from its value on the previous edge, from any state.
REQ-014 SHALL, in SETTLE, count edges with s unchanged; on reaching STABLE_CYCLES go to ARMED.
REQ-015 SHALL, in ARMED, perform exactly one capture evaluation on that edge, then go to HELD; HELD performs no further captures until s changes.
REQ-016 SHALL capture only when exactly one an bit is 0; an=2'b11 or 2'b00 SHALL produce no capture, no upd, no bad change.
REQ-017 SHALL decode seg by inverse of the team hex table: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F (seg[6]..seg[0]).
REQ-018 SHALL on legal pattern: load digit i, set valid[i], clear bad[i], pulse upd.
REQ-019 SHALL on blank pattern 1111111: no capture, no upd, outputs unchanged.
REQ-020 SHALL on any other pattern: hold digit i and valid[i], set bad[i], pulse upd.
REQ-021 SHALL have latency: pins stable from before edge 1 -> synchronizer edges 1-2, stability edges 3..2+STABLE_CYCLES, outputs updated at edge 3+STABLE_CYCLES, upd high for the following cycle only.
REQ-022 SHALL treat a change in s during SETTLE as a restart: counter to 0, no capture.

Reset
REQ-023 SHALL, with reset_n=0, asynchronously clear synchronizer, counter, digit0, digit1, valid, bad, upd, err_count to 0; state to SETTLE.
REQ-024 SHALL, after reset_n deasserts, require a full fresh settle before any capture, including mid-settle or HELD reset.

Configuration
REQ-025 SHALL, with macro SEVSEG_READER_ERRCNT_EN defined, increment err_count on each illegal capture, saturating at 255.
REQ-026 SHALL, without SEVSEG_READER_ERRCNT_EN, tie err_count to 8'h00 with no counter logic; all other behaviour identical.

Verification (STABLE_CYCLES=4)
REQ-027 SHALL cover: seg=0100100, an=2'b10 held 10 cycles -> digit0=4'h2, valid=2'b01, single upd pulse, outputs update at edge 7.
REQ-028 SHALL cover: seg=0110000, an=2'b01 for 2 cycles then seg=1111001 -> no capture from first value; digit1=4'h1 after settling.
REQ-029 SHALL cover: seg=1010101, an=2'b10 held 8 cycles -> bad=2'b01, digit0 unchanged, upd once, err_count=1 with macro / 0 without.
REQ-030 SHALL cover: an=2'b00 or 2'b11 with seg=0000000 held 10 cycles -> no upd, outputs unchanged; seg=1111111 on an=2'b10 -> no upd.
REQ-031 SHALL cover: alternate {an=2'b10,seg=0001000} and {an=2'b01,seg=0110000}, 20 cycles each, 4 rounds -> digit0=4'hA, digit1=4'h3, valid=2'b11, 8 upd pulses.
REQ-032 SHALL cover: reset_n pulsed low at cycle 5 of a settle, then after 3 cycles of HELD -> all outputs 0 immediately; next capture only after full settle.
